// File: rtl/asphalt_led_seq_pkg.sv
// Shared definitions for the asphalt LED sequencer: sequencing modes,
// register word addresses and CTRL bit positions.
package asphalt_led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_DIVISOR = 3'd1;
  localparam logic [2:0] ADDR_PATTERN = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_CURRENT = 3'd4;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IRQ_EN   = 3;

endpackage

// File: rtl/asphalt_led_step_timer.sv
// Step prescaler for the LED sequencer.
// Counts 0..divisor while enabled; on terminal count it reloads 0 and
// raises step for exactly one cycle (registered).
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the count from 0 and drop any pending step
//   enable       : count when high, hold at 0 when low
//   divisor      : step period minus 1
//   step         : one-cycle step pulse
module asphalt_led_step_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  output logic             step
);

  logic [DIV_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      step  <= 1'b0;
    end else if (clear || !enable) begin
      count <= '0;
      step  <= 1'b0;
    end else if (count >= divisor) begin
      // >= rather than == so a divisor lowered mid-count cannot run the
      // counter all the way round the wrap.
      count <= '0;
      step  <= 1'b1;
    end else begin
      count <= count + DIV_W'(1);
      step  <= 1'b0;
    end
  end

endmodule

// File: rtl/asphalt_led_sequencer.sv
// Avalon-MM LED pattern engine. While disabled the CPU drives the LEDs via
// PATTERN; while enabled a step timer advances blink/rotate/bounce patterns
// and flags the end of each pattern cycle as an interrupt.
//   clk, reset_n          : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : zero-wait-state slave write port
//   readdata              : combinational read data selected by address
//   out_port              : registered LED drive
//   irq                   : level interrupt, irq_pending & CTRL.irq_en
module asphalt_led_sequencer
  import asphalt_led_seq_pkg::*;
#(
  parameter int LED_W = 14,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] out_port,
  output logic             irq
);

  localparam int POS_W = $clog2(LED_W);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);

  // Register file
  logic             enable_q, irq_en_q, irq_pending_q;
  mode_e            mode_q;
  logic [DIV_W-1:0] divisor_q;
  logic [LED_W-1:0] pattern_q;

  // Pattern state
  logic [LED_W-1:0] cur_q;
  logic             phase_q;
  logic             dir_right_q;
  logic [POS_W-1:0] pos_q;

  // Next-state values
  logic             enable_d, irq_en_d, irq_pending_d;
  mode_e            mode_d;
  logic [DIV_W-1:0] divisor_d;
  logic [LED_W-1:0] pattern_d, cur_d, out_d;
  logic             phase_d, dir_right_d;
  logic [POS_W-1:0] pos_d;

  logic wr, ctrl_wr, restart, step, cycle_done;

  // Bits of writedata no register holds.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:DIV_W];

  assign wr      = chipselect & ~write_n;
  assign ctrl_wr = wr && (address == ADDR_CTRL);

  asphalt_led_step_timer #(.DIV_W(DIV_W)) u_step_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (restart),
    .enable  (enable_q),
    .divisor (divisor_q),
    .step    (step)
  );

  // NOTE: every signal written here gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    enable_d      = enable_q;
    mode_d        = mode_q;
    irq_en_d      = irq_en_q;
    divisor_d     = divisor_q;
    pattern_d     = pattern_q;
    irq_pending_d = irq_pending_q;
    cur_d         = cur_q;
    phase_d       = phase_q;
    dir_right_d   = dir_right_q;
    pos_d         = pos_q;
    cycle_done    = 1'b0;
    restart       = 1'b0;

    // Register writes
    if (ctrl_wr) begin
      enable_d = writedata[CTRL_ENABLE];
      mode_d   = mode_e'(writedata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
      irq_en_d = writedata[CTRL_IRQ_EN];
      restart  = (enable_d != enable_q) || (mode_d != mode_q);
    end
    if (wr && address == ADDR_DIVISOR) divisor_d = writedata[DIV_W-1:0];
    if (wr && address == ADDR_PATTERN) begin
      pattern_d = writedata[LED_W-1:0];
      restart   = 1'b1;
    end

    // Pattern advance; a restart in the same cycle drops the step.
    if (restart) begin
      cur_d       = pattern_d;
      phase_d     = 1'b1;
      dir_right_d = 1'b0;
      pos_d       = '0;
    end else if (enable_q && step) begin
      unique case (mode_q)
        MODE_BLINK: begin
          phase_d    = ~phase_q;
          cycle_done = ~phase_q;
        end
        MODE_ROTATE: begin
          cur_d      = {cur_q[LED_W-2:0], cur_q[LED_W-1]};
          cycle_done = (pos_q == POS_LAST);
          pos_d      = cycle_done ? '0 : pos_q + POS_W'(1);
        end
        MODE_BOUNCE: begin
          if (!dir_right_q && cur_q[LED_W-1]) begin
            dir_right_d = 1'b1;
            cur_d       = cur_q >> 1;
          end else if (dir_right_q && cur_q[0]) begin
            dir_right_d = 1'b0;
            cur_d       = cur_q << 1;
            cycle_done  = 1'b1;
          end else begin
            cur_d = dir_right_q ? (cur_q >> 1) : (cur_q << 1);
          end
        end
        default: ;  // static ignores steps
      endcase
    end

    // Set beats a simultaneous W1C clear.
    if (wr && address == ADDR_STATUS && writedata[0]) irq_pending_d = 1'b0;
    if (cycle_done) irq_pending_d = 1'b1;

    // LED drive follows the next state so writes show up right after their edge.
    if (!enable_d || mode_d == MODE_STATIC) out_d = pattern_d;
    else if (mode_d == MODE_BLINK)          out_d = phase_d ? pattern_d : '0;
    else                                    out_d = cur_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b0;
      mode_q        <= MODE_STATIC;
      irq_en_q      <= 1'b0;
      divisor_q     <= '0;
      pattern_q     <= '0;
      irq_pending_q <= 1'b0;
      cur_q         <= '0;
      phase_q       <= 1'b1;
      dir_right_q   <= 1'b0;
      pos_q         <= '0;
      out_port      <= '0;
    end else begin
      enable_q      <= enable_d;
      mode_q        <= mode_d;
      irq_en_q      <= irq_en_d;
      divisor_q     <= divisor_d;
      pattern_q     <= pattern_d;
      irq_pending_q <= irq_pending_d;
      cur_q         <= cur_d;
      phase_q       <= phase_d;
      dir_right_q   <= dir_right_d;
      pos_q         <= pos_d;
      out_port      <= out_d;
    end
  end

  assign irq = irq_pending_q & irq_en_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE]                 = enable_q;
        readdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
        readdata[CTRL_IRQ_EN]                 = irq_en_q;
      end
      ADDR_DIVISOR: readdata[DIV_W-1:0] = divisor_q;
      ADDR_PATTERN: readdata[LED_W-1:0] = pattern_q;
      ADDR_STATUS:  readdata[0]         = irq_pending_q;
      ADDR_CURRENT: readdata[LED_W-1:0] = out_port;
      default: ;
    endcase
  end

endmodule
